// File: rtl/pad_cfg_pkg.sv
// Shared types and constants for the pad configuration controller.
// Readback of the active configuration is enabled with the PAD_CFG_READBACK_EN macro.
package pad_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } pad_state_e;

    // Field order matches cfg_data: bit0 cs ... bit5 oe_allow.
    typedef struct packed {
        logic oe_allow;
        logic pd;
        logic pu;
        logic ie;
        logic sl;
        logic cs;
    } pad_attr_t;

    localparam int ATTR_CS_BIT       = 0;
    localparam int ATTR_SL_BIT       = 1;
    localparam int ATTR_IE_BIT       = 2;
    localparam int ATTR_PU_BIT       = 3;
    localparam int ATTR_PD_BIT       = 4;
    localparam int ATTR_OE_ALLOW_BIT = 5;

    localparam pad_attr_t PAD_ATTR_RST = '{
        oe_allow: 1'b0,
        pd:       1'b0,
        pu:       1'b0,
        ie:       1'b1,
        sl:       1'b0,
        cs:       1'b0
    };

    // Pull-up wins when both pulls are requested.
    function automatic logic pad_pd_eff(input pad_attr_t a);
        return a.pd & ~a.pu;
    endfunction

endpackage

// File: rtl/pad_cfg_guard.sv
// Commit sequencer: IDLE -> DRAIN (GUARD_CYCLES cycles, outputs disabled) -> APPLY (1 cycle) -> IDLE.
// The current state is exported so the owner can gate pad enables and checkers can bind to it.
module pad_cfg_guard
    import pad_cfg_pkg::*;
#(
    parameter int GUARD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       commit,
    output pad_state_e state,
    output logic       busy,
    output logic       cfg_ready,
    output logic       apply_en
);

    localparam logic [7:0] GUARD_CNT_INIT = 8'(GUARD_CYCLES);

    logic [7:0] guard_cnt;

    // commit outside IDLE is dropped, never queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            guard_cnt <= 8'd0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            apply_en  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        state     <= ST_DRAIN;
                        guard_cnt <= GUARD_CNT_INIT;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (guard_cnt <= 8'd1) begin
                        state     <= ST_APPLY;
                        guard_cnt <= 8'd0;
                        apply_en  <= 1'b1;
                    end else begin
                        guard_cnt <= guard_cnt - 8'd1;
                    end
                end
                ST_APPLY: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    apply_en  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    guard_cnt <= 8'd0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    apply_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Bidirectional pad configuration: shadow writes, guarded commit into the active set, pad outputs.
// Optional registered readback of the active set is built only when PAD_CFG_READBACK_EN is defined.
module pad_cfg_ctrl
    import pad_cfg_pkg::*;
#(
    parameter int NUM_BIDIR_PADS = 37,
    parameter int GUARD_CYCLES   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [5:0]                cfg_addr,
    input  logic [5:0]                cfg_data,
    input  logic                      commit,
    output logic                      busy,
    output logic                      addr_err,
    input  logic [NUM_BIDIR_PADS-1:0] core_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    output logic [5:0]                cfg_rdata
);

    localparam logic [6:0] PAD_LIMIT = 7'(NUM_BIDIR_PADS);

    pad_state_e state;
    logic       apply_en;
    logic       wr_fire;
    logic       addr_ok;
    logic       pads_enabled;

    pad_attr_t  shadow [NUM_BIDIR_PADS];
    pad_attr_t  active [NUM_BIDIR_PADS];

    pad_cfg_guard #(
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_guard (
        .clk       (clk),
        .rst       (rst),
        .commit    (commit),
        .state     (state),
        .busy      (busy),
        .cfg_ready (cfg_ready),
        .apply_en  (apply_en)
    );

    // Handshake: a write transfers on a rising edge where cfg_valid && cfg_ready; cfg_ready is
    // high only in IDLE, so a same-edge commit always sees the write already in the shadow.
    assign wr_fire      = cfg_valid && cfg_ready;
    assign addr_ok      = {1'b0, cfg_addr} < PAD_LIMIT;
    assign pads_enabled = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
                shadow[i] <= PAD_ATTR_RST;
                active[i] <= PAD_ATTR_RST;
            end
        end else begin
            for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
                if (wr_fire && (cfg_addr == 6'(i))) begin
                    shadow[i] <= pad_attr_t'(cfg_data);
                end
                if (apply_en) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (wr_fire && !addr_ok) begin
            addr_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_BIDIR_PADS; g++) begin : g_pad
        assign bidir_oe[g] = core_oe[g] & active[g].oe_allow & pads_enabled;
        assign bidir_cs[g] = active[g].cs;
        assign bidir_sl[g] = active[g].sl;
        assign bidir_ie[g] = active[g].ie;
        assign bidir_pu[g] = active[g].pu;
        assign bidir_pd[g] = pad_pd_eff(active[g]);
    end

`ifdef PAD_CFG_READBACK_EN
    pad_attr_t rd_mux;

    // Out-of-range addresses match no entry and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
            if (cfg_addr == 6'(i)) begin
                rd_mux = active[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata <= 6'd0;
        end else begin
            cfg_rdata <= rd_mux;
        end
    end
`else
    assign cfg_rdata = 6'd0;
`endif

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed bench for pad_cfg_ctrl with a shadow/active model and a commit scoreboard.
// Readback checks follow PAD_CFG_READBACK_EN.
module tb_pad_cfg_ctrl;
    import pad_cfg_pkg::*;

    localparam int N = 37;
    localparam int G = 4;
    localparam int W = 5 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         commit = 1'b0;
    logic [5:0]   cfg_addr = 6'd0;
    logic [5:0]   cfg_data = 6'd0;
    logic [N-1:0] core_oe = '1;

    logic         cfg_ready, busy, addr_err;
    logic [N-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic [5:0]   cfg_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];
    logic [5:0]   m_shadow [N];
    logic [5:0]   m_active [N];

    pad_cfg_ctrl #(
        .NUM_BIDIR_PADS (N),
        .GUARD_CYCLES   (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .commit    (commit),
        .busy      (busy),
        .addr_err  (addr_err),
        .core_oe   (core_oe),
        .bidir_oe  (bidir_oe),
        .bidir_cs  (bidir_cs),
        .bidir_sl  (bidir_sl),
        .bidir_ie  (bidir_ie),
        .bidir_pu  (bidir_pu),
        .bidir_pd  (bidir_pd),
        .cfg_rdata (cfg_rdata)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 6'b000100;
            m_active[i] = 6'b000100;
        end
    endtask

    task automatic m_write(input logic [5:0] addr, input logic [5:0] data);
        int idx;
        idx = int'(addr);
        if (idx < N) m_shadow[idx] = data;
    endtask

    function automatic logic [W-1:0] attr_vec(input logic use_shadow);
        logic [N-1:0] cs, sl, ie, pu, pd;
        logic [5:0]   a;
        for (int i = 0; i < N; i++) begin
            a     = use_shadow ? m_shadow[i] : m_active[i];
            cs[i] = a[ATTR_CS_BIT];
            sl[i] = a[ATTR_SL_BIT];
            ie[i] = a[ATTR_IE_BIT];
            pu[i] = a[ATTR_PU_BIT];
            pd[i] = a[ATTR_PD_BIT] && !a[ATTR_PU_BIT];
        end
        return {cs, sl, ie, pu, pd};
    endfunction

    function automatic logic [N-1:0] exp_oe();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = core_oe[i] & m_active[i][ATTR_OE_ALLOW_BIT];
        return r;
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd};
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, W'(busy), '0);
        check({tag, " ready"}, W'(cfg_ready), W'(1'b1));
        check({tag, " attrs"}, obs_vec(), attr_vec(1'b0));
        check({tag, " oe"}, W'(bidir_oe), W'(exp_oe()));
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [5:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        tick();
        cfg_valid = 1'b0;
        m_write(addr, data);
    endtask

    // Commit (optionally with a same-edge write); poke tries a write and a commit while busy.
    task automatic do_commit(input logic wr, input logic [5:0] addr, input logic [5:0] data,
                             input logic poke, input string tag);
        logic [W-1:0] e;
        commit = 1'b1;
        if (wr) begin
            cfg_valid = 1'b1;
            cfg_addr  = addr;
            cfg_data  = data;
        end
        tick();
        commit    = 1'b0;
        cfg_valid = 1'b0;
        if (wr) m_write(addr, data);
        exp_q.push_back(attr_vec(1'b1));
        for (int k = 1; k <= G + 1; k++) begin
            check({tag, " busy_hi"}, W'(busy), W'(1'b1));
            check({tag, " ready_lo"}, W'(cfg_ready), '0);
            check({tag, " oe_guard"}, W'(bidir_oe), '0);
            check({tag, " attr_hold"}, obs_vec(), attr_vec(1'b0));
            if (poke && k == 2) begin
                cfg_valid = 1'b1;
                cfg_addr  = 6'd9;
                cfg_data  = 6'h3f;
                commit    = 1'b1;
            end else begin
                cfg_valid = 1'b0;
                commit    = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
        check({tag, " busy_lo"}, W'(busy), '0);
        check({tag, " ready_hi"}, W'(cfg_ready), W'(1'b1));
        if (exp_q.size() == 0) begin
            check({tag, " sb_empty"}, W'(1'b1), '0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " sb_attrs"}, obs_vec(), e);
        end
        check({tag, " oe_after"}, W'(bidir_oe), W'(exp_oe()));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [N-1:0] pad3_only;
        logic [63:0]  r64;
        logic [5:0]   ra, rd;

        m_reset();
        rst     = 1'b1;
        core_oe = '1;
        tick();
        tick();
        check("rst oe", W'(bidir_oe), '0);
        check("rst ie", W'(bidir_ie), W'({N{1'b1}}));
        check("rst busy", W'(busy), '0);
        check("rst ready", W'(cfg_ready), W'(1'b1));
        check("rst addr_err", W'(addr_err), '0);
        rst = 1'b0;
        tick();
        check_idle("post_rst");

        // basic commit on pad 3
        cfg_write(6'd3, 6'h24);
        check_idle("wr3 no_effect");
        do_commit(1'b0, 6'd0, 6'd0, 1'b0, "commit3");
        pad3_only    = '0;
        pad3_only[3] = 1'b1;
        check("pad3 oe_only", W'(bidir_oe), W'(pad3_only));
        for (int j = 0; j < 3; j++) begin
            r64     = {$urandom(), $urandom()};
            core_oe = r64[N-1:0];
            #1;
            check("pad3 oe_follow", W'(bidir_oe), W'(exp_oe()));
        end
        core_oe = '1;

`ifdef PAD_CFG_READBACK_EN
        cfg_addr = 6'd3;
        tick();
        check("rdback pad3", W'(cfg_rdata), W'(6'h24));
        cfg_addr = 6'd40;
        tick();
        check("rdback oor", W'(cfg_rdata), '0);
`else
        cfg_addr = 6'd3;
        tick();
        check("rdata zero", W'(cfg_rdata), '0);
`endif

        // guard: drop ie and keep oe_allow on pad 3
        cfg_write(6'd3, 6'h20);
        do_commit(1'b0, 6'd0, 6'd0, 1'b0, "guard3");
        check("guard3 ie3", W'(bidir_ie[3]), '0);
        check("guard3 oe3", W'(bidir_oe[3]), W'(1'b1));

        // simultaneous write+commit, plus write/commit attempts while busy
        do_commit(1'b1, 6'd5, 6'h08, 1'b1, "wrcommit5");
        check("wrcommit5 pu5", W'(bidir_pu[5]), W'(1'b1));
        tick();
        tick();
        check("no_queued busy", W'(busy), '0);
        do_commit(1'b0, 6'd0, 6'd0, 1'b0, "shadow9_untouched");

        // out-of-range writes and boundary pad
        cfg_write(6'd40, 6'h3f);
        check("oor40 addr_err", W'(addr_err), W'(1'b1));
        check_idle("oor40 no_effect");
        cfg_write(6'd37, 6'h3f);
        cfg_write(6'd36, 6'h21);
        tick();
        tick();
        check("addr_err sticky", W'(addr_err), W'(1'b1));
        cfg_write(6'd0, 6'h18);
        do_commit(1'b0, 6'd0, 6'd0, 1'b0, "conflict0");
        check("conflict0 pu0", W'(bidir_pu[0]), W'(1'b1));
        check("conflict0 pd0", W'(bidir_pd[0]), '0);
        check("conflict0 cs36", W'(bidir_cs[36]), W'(1'b1));

        // random writes and commits
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 3; j++) begin
                ra = 6'($urandom_range(0, N - 1));
                rd = 6'($urandom_range(0, 63));
                cfg_write(ra, rd);
            end
            r64     = {$urandom(), $urandom()};
            core_oe = r64[N-1:0];
            do_commit(1'b0, 6'd0, 6'd0, 1'b0, "rand");
        end
        core_oe = '1;

        // reset in the middle of DRAIN
        commit    = 1'b1;
        cfg_valid = 1'b1;
        cfg_addr  = 6'd7;
        cfg_data  = 6'h3f;
        tick();
        commit    = 1'b0;
        cfg_valid = 1'b0;
        m_write(6'd7, 6'h3f);
        exp_q.push_back(attr_vec(1'b1));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        exp_q.delete();
        check("midrst attrs", obs_vec(), attr_vec(1'b0));
        check("midrst busy", W'(busy), '0);
        check("midrst addr_err", W'(addr_err), '0);
        check("midrst oe", W'(bidir_oe), '0);
        for (int k = 0; k < G + 3; k++) tick();
        check_idle("midrst no_late_apply");
        do_commit(1'b0, 6'd0, 6'd0, 1'b0, "midrst shadow_cleared");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pad_cfg_ctrl.md
PAD_CFG_CTRL -- requirements
Module: pad_cfg_ctrl

Interface
REQ-001 Parameter NUM_BIDIR_PADS, default 37, number of bidirectional pads controlled.
REQ-002 Parameter GUARD_CYCLES, default 4, range 1..255, number of cycles all output enables are held low before a new configuration is applied.
REQ-003 clk  input  1  single core clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cfg_valid  input  1  write request into the shadow configuration.
REQ-006 cfg_ready  output  1  write acceptance; a write occurs when cfg_valid and cfg_ready are both high on the same edge.
REQ-007 cfg_addr  input  6  pad index.
REQ-008 cfg_data  input  6  pad attributes: bit0 cs, bit1 sl, bit2 ie, bit3 pu, bit4 pd, bit5 oe_allow.
REQ-009 commit  input  1  single-cycle request to apply the shadow configuration.
REQ-010 busy  output  1  high while a commit sequence is in progress.
REQ-011 addr_err  output  1  sticky flag for an accepted write with cfg_addr >= NUM_BIDIR_PADS.
REQ-012 core_oe  input  NUM_BIDIR_PADS  output-enable requests from core logic.
REQ-013 bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd  output  NUM_BIDIR_PADS each  pad control outputs.
REQ-014 cfg_rdata  output  6  readback of the active configuration (see REQ-030).

Function
REQ-015 FSM states are IDLE, DRAIN and APPLY; busy SHALL be high in every state except IDLE.
REQ-016 cfg_ready SHALL be high only in IDLE.
REQ-017 An accepted write with an in-range cfg_addr SHALL update only that pad's shadow entry; it SHALL NOT alter any pad output.
REQ-018 An accepted write with an out-of-range cfg_addr SHALL change no shadow entry and SHALL set addr_err; addr_err clears only on rst.
REQ-019 In IDLE, commit SHALL move the FSM to DRAIN; commit is ignored in DRAIN and APPLY, and is not queued.
REQ-020 If cfg_valid, cfg_ready and commit are all high on the same edge, the write SHALL land in the shadow first, and the commit SHALL apply that write.
REQ-021 DRAIN SHALL last exactly GUARD_CYCLES cycles, counted by an 8-bit down-counter; APPLY SHALL then last 1 cycle, at whose end active <= shadow for all pads; the FSM then returns to IDLE.
REQ-022 Timing: commit sampled at edge t gives busy=1 for cycles t+1 .. t+GUARD_CYCLES+1; new attributes are visible and busy=0 from cycle t+GUARD_CYCLES+2.
REQ-023 bidir_oe[i] SHALL equal core_oe[i] AND active oe_allow[i] AND (state == IDLE), and SHALL be combinational from registered state.
REQ-024 bidir_cs, bidir_sl, bidir_ie, bidir_pu and bidir_pd SHALL come directly from the active registers and SHALL change only at the end of APPLY.
REQ-025 If the active entry has pu and pd both set, bidir_pd SHALL be forced to 0 (pull-up wins).

Reset
REQ-026 While rst is high, the FSM SHALL go to IDLE, the counter SHALL clear, and addr_err SHALL be 0.
REQ-027 While rst is high, every shadow and active entry SHALL be set to cs=0, sl=0, ie=1, pu=0, pd=0, oe_allow=0; all bidir_oe are therefore 0 and bidir_ie is all-ones.
REQ-028 If rst is asserted during DRAIN or APPLY, the sequence SHALL be abandoned and no partial apply SHALL occur.

Configuration
REQ-029 Readback is controlled by the macro PAD_CFG_READBACK_EN.
REQ-030 With PAD_CFG_READBACK_EN defined, cfg_rdata SHALL register the active entry at cfg_addr on every edge (1-cycle latency), and SHALL be 0 for an out-of-range cfg_addr. Without it, cfg_rdata SHALL be constant 0 and no read mux SHALL be built.

Structure
REQ-031 A shared package pad_cfg_pkg SHALL hold the state enum, the packed pad_attr_t (cs, sl, ie, pu, pd, oe_allow), the reset constant PAD_ATTR_RST and the bit-index constants.
REQ-032 One sub-module, pad_cfg_guard, SHALL contain the FSM and the guard counter; the shadow and active arrays SHALL live in pad_cfg_ctrl.

Verification
REQ-033 Reset: hold rst 2 cycles, core_oe all-ones -> bidir_oe=0, bidir_ie all-ones, busy=0, cfg_ready=1, addr_err=0.
REQ-034 Basic commit: write addr 3 data 0x24 (ie, oe_allow), GUARD_CYCLES=4, commit at t -> busy high t+1..t+5, bidir_oe[3] follows core_oe[3] from t+6, bidir_oe of other pads stays 0.
REQ-035 Guard: pad 3 active with core_oe[3]=1, commit new data 0x20 -> bidir_oe[3]=0 throughout t+1..t+5, bidir_ie[3] stays 1 until t+6, then becomes 0.
REQ-036 Simultaneous write+commit: addr 5 data 0x08 with commit on the same edge -> bidir_pu[5]=1 at t+6; a cfg_valid during busy sees cfg_ready=0 and changes no shadow entry.
REQ-037 Errors/conflicts: write addr 40 -> addr_err=1 and stays set, no pad changes; write pad 0 with data 0x18 and commit -> bidir_pu[0]=1, bidir_pd[0]=0.
REQ-038 Reset mid-sequence: pulse rst at t+3 -> the active configuration returns to PAD_ATTR_RST. With PAD_CFG_READBACK_EN, read addr 3 after REQ-034 -> cfg_rdata=0x24 one cycle later.
